// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit path and its register wrapper.
package uart_pkg;

    localparam int unsigned DEFAULT_CLKS_PER_BIT = 868;
    localparam int unsigned TX_READY_BIT         = 0;
    localparam int unsigned DATA_W               = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_t;

endpackage

// File: rtl/uart_tx_if.sv
// Byte push handshake between the register wrapper and the transmit engine.
interface uart_tx_if;
    import uart_pkg::*;

    logic [DATA_W-1:0] tx_data;
    logic              tx_valid;
    logic              tx_ready;

    modport master (output tx_data, output tx_valid, input  tx_ready);
    modport slave  (input  tx_data, input  tx_valid, output tx_ready);

endinterface

// File: rtl/uart_sync_fifo.sv
// Single-clock FIFO; full/empty are registered decodes of the next occupancy.
module uart_sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16
) (
    input  logic                         clk,
    input  logic                         rstn,
    input  logic                         push,
    input  logic                         pop,
    input  logic [WIDTH-1:0]             din,
    output logic [WIDTH-1:0]             dout,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         full,
    output logic                         empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count_next;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    always_comb begin
        count_next = count;
        case ({do_push, do_pop})
            2'b10:   count_next = count + CNT_W'(1);
            2'b01:   count_next = count - CNT_W'(1);
            default: count_next = count;
        endcase
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count_next;
            full  <= (count_next == CNT_W'(DEPTH));
            empty <= (count_next == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/uart_tx_engine.sv
// Buffered 8N1 transmitter: byte FIFO feeding a baud-timed bit serializer.
module uart_tx_engine
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int unsigned FIFO_DEPTH   = 16
) (
    input  logic                              clk,
    input  logic                              rstn,
    uart_tx_if.slave                          bus,
    output logic                              tx_busy,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_count,
    output logic                              uart_tx_pin
);

    localparam int unsigned       BAUD_W    = $clog2(CLKS_PER_BIT);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

    tx_state_t         state;
    logic [BAUD_W-1:0] baud_cnt;
    logic [2:0]        bit_idx;
    logic [DATA_W-1:0] shreg;
    logic [DATA_W-1:0] fifo_dout;
    logic              fifo_full;
    logic              fifo_empty;
    logic              baud_last;
    logic              pop;

    assign baud_last = (baud_cnt == BAUD_LAST);
    // Pop from IDLE, or at the end of STOP so the next start bit follows with no gap.
    assign pop = !fifo_empty && ((state == IDLE) || (state == STOP && baud_last));

    uart_sync_fifo #(
        .WIDTH (DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rstn  (rstn),
        .push  (bus.tx_valid),
        .pop   (pop),
        .din   (bus.tx_data),
        .dout  (fifo_dout),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign bus.tx_ready = !fifo_full;
    assign tx_busy      = (state != IDLE) || !fifo_empty;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state       <= IDLE;
            baud_cnt    <= '0;
            bit_idx     <= '0;
            shreg       <= '0;
            uart_tx_pin <= 1'b1;
        end else begin
            baud_cnt <= (state == IDLE || baud_last) ? '0 : baud_cnt + BAUD_W'(1);
            case (state)
                IDLE: begin
                    uart_tx_pin <= 1'b1;
                    if (pop) begin
                        shreg       <= fifo_dout;
                        bit_idx     <= '0;
                        state       <= START;
                        uart_tx_pin <= 1'b0;
                    end
                end
                START: begin
                    if (baud_last) begin
                        state       <= DATA;
                        uart_tx_pin <= shreg[0];
                    end
                end
                DATA: begin
                    if (baud_last) begin
                        if (bit_idx == 3'd7) begin
                            state       <= STOP;
                            uart_tx_pin <= 1'b1;
                        end else begin
                            bit_idx     <= bit_idx + 3'd1;
                            shreg       <= shreg >> 1;
                            uart_tx_pin <= shreg[1];
                        end
                    end
                end
                STOP: begin
                    if (baud_last) begin
                        if (pop) begin
                            shreg       <= fifo_dout;
                            bit_idx     <= '0;
                            state       <= START;
                            uart_tx_pin <= 1'b0;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: begin
                    state       <= IDLE;
                    uart_tx_pin <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_engine.sv
// Scoreboard bench for uart_tx_engine: a line monitor decodes frames and checks them against queued bytes.
module tb_uart_tx_engine;
    import uart_pkg::*;

    localparam int unsigned CPB   = 4;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned FRAME = 10 * CPB;

    logic       clk = 1'b0;
    logic       rstn;
    logic       tx_busy;
    logic [2:0] fifo_count;
    logic       uart_tx_pin;

    uart_tx_if bus();

    uart_tx_engine #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .clk         (clk),
        .rstn        (rstn),
        .bus         (bus),
        .tx_busy     (tx_busy),
        .fifo_count  (fifo_count),
        .uart_tx_pin (uart_tx_pin)
    );

    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_bad = 0;
    int unsigned cyc   = 0;
    int          frames_seen = 0;
    logic [7:0]  exp_q [$];
    int unsigned start_q [$];
    logic [2:0]  peak = '0;
    logic [7:0]  b2b_vec [3] = '{8'h55, 8'hAA, 8'h0F};
    logic [7:0]  rst_vec [3] = '{8'h33, 8'h44, 8'h99};
    logic [31:0] status;
    int          lows;

    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (fifo_count > peak) peak = fifo_count;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input string name, input int budget);
        int i;
        i = 0;
        while (tx_busy !== 1'b0 && i < budget) begin
            step(1);
            i++;
        end
        check(name, 32'(tx_busy), 32'd0);
    endtask

    // Line monitor: samples each negedge, decodes a whole frame, compares with the scoreboard.
    initial begin : monitor
        logic       s [FRAME];
        logic       ok;
        logic       aborted;
        logic [7:0] b;
        forever begin
            @(negedge clk);
            if (rstn === 1'b1 && uart_tx_pin === 1'b0) begin
                start_q.push_back(cyc);
                s[0]    = 1'b0;
                aborted = 1'b0;
                for (int i = 1; i < FRAME; i++) begin
                    @(negedge clk);
                    if (rstn !== 1'b1) begin
                        aborted = 1'b1;
                        break;
                    end
                    s[i] = uart_tx_pin;
                end
                if (!aborted) begin
                    ok = 1'b1;
                    for (int i = 0; i < FRAME; i++)
                        if (s[i] !== s[(i / CPB) * CPB]) ok = 1'b0;
                    if (s[0] !== 1'b0 || s[FRAME-1] !== 1'b1) ok = 1'b0;
                    b = '0;
                    for (int k = 0; k < 8; k++) b[k] = s[(k + 1) * CPB];
                    check("frame_shape", 32'(ok), 32'd1);
                    if (exp_q.size() == 0) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL frame_unexpected: got 0x%0h expected no frame", b);
                    end else begin
                        check("frame_data", 32'(b), 32'(exp_q.pop_front()));
                    end
                    frames_seen++;
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "simulation time limit reached");
    end

    initial begin : stimulus
        rstn         = 1'b0;
        bus.tx_valid = 1'b0;
        bus.tx_data  = '0;
        step(3);
        check("rst_pin",   32'(uart_tx_pin),  32'd1);
        check("rst_ready", 32'(bus.tx_ready), 32'd1);
        check("rst_busy",  32'(tx_busy),      32'd0);
        check("rst_count", 32'(fifo_count),   32'd0);
        rstn = 1'b1;
        step(2);

        // Single byte 0x41
        bus.tx_data  = 8'h41;
        bus.tx_valid = 1'b1;
        exp_q.push_back(8'h41);
        step(1);
        bus.tx_valid = 1'b0;
        check("single_count_after_push", 32'(fifo_count), 32'd1);
        check("single_pin_before_start", 32'(uart_tx_pin), 32'd1);
        step(1);
        check("single_start_bit", 32'(uart_tx_pin), 32'd0);
        check("single_count_after_pop", 32'(fifo_count), 32'd0);
        step(39);
        check("single_busy_last", 32'(tx_busy), 32'd1);
        step(1);
        check("single_busy_fall", 32'(tx_busy), 32'd0);
        step(3);
        check("single_frames", 32'(frames_seen), 32'd1);

        // Back-to-back 0x55, 0xAA, 0x0F
        peak = '0;
        start_q.delete();
        for (int i = 0; i < 3; i++) begin
            bus.tx_data  = b2b_vec[i];
            bus.tx_valid = 1'b1;
            exp_q.push_back(b2b_vec[i]);
            step(1);
        end
        bus.tx_valid = 1'b0;
        check("b2b_count", 32'(fifo_count), 32'd2);
        wait_idle("b2b_idle", 200);
        step(2);
        check("b2b_peak", 32'(peak), 32'd2);
        check("b2b_frames", 32'(start_q.size()), 32'd3);
        if (start_q.size() == 3) begin
            check("b2b_gap1", 32'(start_q[1] - start_q[0]), 32'(FRAME));
            check("b2b_gap2", 32'(start_q[2] - start_q[1]), 32'(FRAME));
        end

        // Overflow 0x01..0x06, then full plus pop at the end of the first STOP
        for (int i = 0; i < 6; i++) begin
            bus.tx_data  = 8'(i + 1);
            bus.tx_valid = 1'b1;
            if (i < 5) exp_q.push_back(8'(i + 1));
            step(1);
            if (i == 4) begin
                check("ovf_full_count", 32'(fifo_count), 32'd4);
                status = 32'(bus.tx_ready) << TX_READY_BIT;
                check("status_full", 32'(status[TX_READY_BIT]), 32'd0);
            end
        end
        bus.tx_valid = 1'b0;
        check("ovf_drop_count", 32'(fifo_count), 32'd4);
        step(34);
        bus.tx_data  = 8'h77;
        bus.tx_valid = 1'b1;
        step(1);
        check("fullpop_count_before", 32'(fifo_count), 32'd4);
        check("fullpop_ready_before", 32'(bus.tx_ready), 32'd0);
        step(1);
        bus.tx_valid = 1'b0;
        check("fullpop_count_after", 32'(fifo_count), 32'd3);
        status = 32'(bus.tx_ready) << TX_READY_BIT;
        check("status_after_frame", 32'(status[TX_READY_BIT]), 32'd1);
        wait_idle("ovf_idle", 300);
        step(2);
        check("ovf_drained", 32'(exp_q.size()), 32'd0);

        // Reset during DATA bit 3 of 0x33 with two bytes queued
        for (int i = 0; i < 3; i++) begin
            bus.tx_data  = rst_vec[i];
            bus.tx_valid = 1'b1;
            exp_q.push_back(rst_vec[i]);
            step(1);
        end
        bus.tx_valid = 1'b0;
        check("rst_mid_queued", 32'(fifo_count), 32'd2);
        step(16);
        check("rst_mid_bit3", 32'(uart_tx_pin), 32'd0);
        rstn = 1'b0;
        exp_q.delete();
        step(1);
        check("rst_mid_pin",   32'(uart_tx_pin),  32'd1);
        check("rst_mid_count", 32'(fifo_count),   32'd0);
        check("rst_mid_ready", 32'(bus.tx_ready), 32'd1);
        check("rst_mid_busy",  32'(tx_busy),      32'd0);
        rstn = 1'b1;
        start_q.delete();
        lows = 0;
        for (int i = 0; i < 100; i++) begin
            step(1);
            if (uart_tx_pin !== 1'b1) lows++;
        end
        check("rst_no_frame_low", 32'(lows), 32'd0);
        check("rst_no_frame_starts", 32'(start_q.size()), 32'd0);
        check("rst_end_busy", 32'(tx_busy), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/uart_tx_engine.md
# uart_tx_engine

Buffered 8N1 UART transmitter that sits directly downstream of the memory-mapped UART register wrapper. The wrapper's data-register write at 0x1faf0000 pushes one byte here. The wrapper's status-register read at 0x1faf0004 returns `tx_ready` as bit 0. Internally the block holds a small FIFO and a bit serializer that drives `uart_tx_pin`, so the CPU can issue several bytes without polling between them.

## Interface
Parameters:
- `CLKS_PER_BIT`, default 868: clock cycles per UART bit (100 MHz / 115200). Legal range is 2 or more.
- `FIFO_DEPTH`, default 16: number of byte entries. Must be a power of 2, at least 2.

Ports:
- `clk`: input, 1 bit. Single clock; all logic is on the rising edge.
- `rstn`: input, 1 bit. Synchronous, active-low reset, sampled on the rising edge of `clk`.
- `tx_data`: input, 8 bits. Byte to enqueue.
- `tx_valid`: input, 1 bit. Push request, one byte per cycle.
- `tx_ready`: output, 1 bit. Equals `!fifo_full`. This is status bit 0 as read by the CPU.
- `tx_busy`: output, 1 bit. High when the serializer is not IDLE or the FIFO is non-empty.
- `fifo_count`: output, $clog2(FIFO_DEPTH+1) bits. Number of bytes currently queued.
- `uart_tx_pin`: output, 1 bit. Serial line, idle high. Registered.

## Operation
- **Push:** a byte is accepted on a rising edge where `tx_valid && tx_ready`.
  - `tx_valid` while full is ignored and the byte is dropped. There is no error flag.
  - `tx_valid` is single-cycle. The source must not hold it expecting retry.
- **Serializer FSM:** states are IDLE, START, DATA, STOP.
  - **IDLE:** the pin is 1. If the FIFO is non-empty at the edge: pop the head into the shift register, go to START, and clear the bit counter.
  - **START:** the pin is 0 for CLKS_PER_BIT cycles, then go to DATA.
  - **DATA:** 8 bits, LSB first, each held CLKS_PER_BIT cycles. A 3-bit index counts 0..7. After bit 7, go to STOP.
  - **STOP:** the pin is 1 for CLKS_PER_BIT cycles.
    - At the end of STOP, if the FIFO is non-empty, pop and go straight to START (no idle gap).
    - Otherwise go to IDLE.
- **Baud counter:** counts 0..CLKS_PER_BIT-1. It wraps to 0 and advances the bit or state on the terminal count. The counter width is $clog2(CLKS_PER_BIT).
- **Simultaneous push and pop:** both take effect and `fifo_count` is unchanged.
  - When full: the pop happens, and the push is dropped because `tx_ready` was 0 in that cycle.
  - When empty in IDLE: a pop is not possible in the same cycle as the push. The pushed byte pops on the next edge.
- **Pointers:** read and write pointers wrap modulo FIFO_DEPTH. Full/empty is derived from `fifo_count`.
- **Reset:** reset is synchronous and active-low, and applies at any time, including mid-frame.
  - Effect: the frame is aborted, the FIFO is flushed, the FSM goes to IDLE, and the pin goes to 1 on the edge where `rstn` = 0 is sampled.
  - A truncated frame on the line is acceptable.

## Timing
- **Reset values:**
  - `uart_tx_pin` = 1
  - `tx_ready` = 1
  - `tx_busy` = 0
  - `fifo_count` = 0
- **Push to start bit:** push accepted at edge N; `fifo_count` = 1 after N. The pop happens at edge N+1, and `uart_tx_pin` = 0 from N+1.
- **Frame length:** exactly 10 × CLKS_PER_BIT cycles. Back-to-back frames have zero idle cycles between the stop bit and the next start bit.
- **`tx_ready` updates:** updates the cycle after the count change. It drops after the push that makes the count equal FIFO_DEPTH, and rises after the next pop.
- **`tx_busy` de-assertion:** falls on the edge that enters IDLE with the FIFO empty.

## Structure
- **Package `uart_pkg`:**
  - the state enum (IDLE, START, DATA, STOP)
  - the default CLKS_PER_BIT
  - the status-bit index constant (TX_READY_BIT = 0)

  The wrapper imports this package for the status-bit index.
- **Sub-module `uart_sync_fifo`:** parameterised on width and depth. It provides push, pop, dout (head, valid when non-empty), count, full and empty.
- **Top:** the serializer FSM and baud counter live in `uart_tx_engine` itself.

## Test plan
All scenarios run with CLKS_PER_BIT = 4 and FIFO_DEPTH = 4.
- **Single byte:** push 0x41 -> the pin reads 0,1,0,0,0,0,0,1,0,1, each value held exactly 4 cycles. The start bit begins 1 edge after the push. `tx_busy` falls after 40 cycles.
- **Back-to-back:** push 0x55, 0xAA, 0x0F on consecutive cycles -> three contiguous 40-cycle frames with no idle cycle between them. `fifo_count` peaks at 2.
- **Overflow:** push 0x01..0x06 on consecutive cycles with the serializer idle.
  - 0x01 pops, and 0x02..0x05 fill the FIFO.
  - `tx_ready` goes 0, and 0x06 is dropped.
  - The line carries 0x01..0x05 only.
- **Full plus pop:** with the FIFO full, hold `tx_valid` through the cycle where STOP ends -> the pop occurs, the push in the full cycle is dropped, and `fifo_count` goes 4 -> 3.
- **Reset mid-frame:** with 2 bytes queued, assert `rstn` = 0 during DATA bit 3.
  - Next edge: the pin is 1, `fifo_count` = 0, `tx_ready` = 1.
  - After release, no further frame is sent.
- **Status read:** the wrapper reads status while the engine is full, then after one frame completes -> bit 0 reads 0, then 1.
